// File: rtl/reuleaux_arc_if.sv
// Start/done drawing handshake plus VGA pixel bus shared by the Reuleaux plotter
// and the top-level draw FSM.
interface reuleaux_arc_if #(
  parameter int unsigned XW = 8,
  parameter int unsigned YW = 7,
  parameter int unsigned CW = 3
) ();
  logic          start;
  logic [CW-1:0] colour;
  logic [XW-1:0] centre_x;
  logic [YW-1:0] centre_y;
  logic [XW-1:0] diameter;
  logic          done;
  logic [XW-1:0] vga_x;
  logic [YW-1:0] vga_y;
  logic [CW-1:0] vga_colour;
  logic          vga_plot;

  modport master (
    output start, colour, centre_x, centre_y, diameter,
    input  done, vga_x, vga_y, vga_colour, vga_plot
  );

  modport slave (
    input  start, colour, centre_x, centre_y, diameter,
    output done, vga_x, vga_y, vga_colour, vga_plot
  );
endinterface

// File: rtl/reuleaux_arc.sv
// Reuleaux-triangle plotter: one midpoint-circle engine swept over three vertex arcs.
// Define REULEAUX_CLIP_EN for per-arc region clipping; otherwise three full circles.
module reuleaux_arc #(
  parameter int unsigned XW       = 8,
  parameter int unsigned YW       = 7,
  parameter int unsigned CW       = 3,
  parameter int unsigned SCREEN_W = 160,
  parameter int unsigned SCREEN_H = 120
) (
  input logic          clk,
  input logic          rst,
  reuleaux_arc_if.slave bus
);
  localparam int unsigned W   = XW + 3;
  localparam int unsigned CRW = W + 2;
  localparam int unsigned PW  = XW + 7;

  typedef logic signed [W-1:0]   coord_t;
  typedef logic signed [CRW-1:0] crit_t;

  localparam coord_t ScrW    = coord_t'(SCREEN_W);
  localparam coord_t ScrH    = coord_t'(SCREEN_H);
  localparam coord_t CoordOne = coord_t'(1);
  localparam crit_t  CritOne = crit_t'(1);

  typedef enum logic [1:0] {StIdle, StSetup, StArc, StDone} state_e;

  state_e        state_q, state_d;
  logic [CW-1:0] colour_q, colour_d;
  logic [XW-1:0] cx_q, cx_d, diam_q, diam_d;
  logic [YW-1:0] cy_q, cy_d;
  coord_t        ay_q, ay_d, bx_q, bx_d, rx_q, rx_d, ly_q, ly_d;
  logic [1:0]    arc_q, arc_d;
  logic [2:0]    oct_q, oct_d;
  coord_t        ox_q, ox_d, oy_q, oy_d;
  crit_t         crit_q, crit_d;
  logic [XW-1:0] vga_x_q, vga_x_d;
  logic [YW-1:0] vga_y_q, vga_y_d;
  logic [CW-1:0] vga_col_q, vga_col_d;
  logic          plot_q, plot_d, done_q, done_d;

  // Vertex geometry from the latched inputs
  logic [PW-1:0] p37, p74;
  coord_t        h1, h2, half, cx_s, cy_s, d_s;

  always_comb begin
    p37  = PW'(diam_q) * PW'(37);
    p74  = PW'(diam_q) * PW'(74);
    h1   = coord_t'(p37 >> 7);
    h2   = coord_t'(p74 >> 7);
    half = coord_t'(diam_q >> 1);
    cx_s = coord_t'(cx_q);
    cy_s = coord_t'(cy_q);
    d_s  = coord_t'(diam_q);
  end

  coord_t vx, vy, dx, dy, cand_x, cand_y;
  logic   on_screen, in_region;

  always_comb begin
    case (arc_q)
      2'd1:    begin vx = bx_q; vy = ly_q; end
      2'd2:    begin vx = rx_q; vy = ly_q; end
      default: begin vx = cx_s; vy = ay_q; end
    endcase
    unique case (oct_q)
      3'd0: begin dx =  ox_q; dy =  oy_q; end
      3'd1: begin dx =  oy_q; dy =  ox_q; end
      3'd2: begin dx = -oy_q; dy =  ox_q; end
      3'd3: begin dx = -ox_q; dy =  oy_q; end
      3'd4: begin dx = -ox_q; dy = -oy_q; end
      3'd5: begin dx = -oy_q; dy = -ox_q; end
      3'd6: begin dx =  oy_q; dy = -ox_q; end
      3'd7: begin dx =  ox_q; dy = -oy_q; end
    endcase
    cand_x    = vx + dx;
    cand_y    = vy + dy;
    on_screen = !cand_x[W-1] && (cand_x < ScrW) && !cand_y[W-1] && (cand_y < ScrH);
`ifdef REULEAUX_CLIP_EN
    case (arc_q)
      2'd0:    in_region = (cand_y >= ly_q);
      2'd1:    in_region = (cand_x >= cx_s) && (cand_y <= ly_q);
      2'd2:    in_region = (cand_x <= cx_s) && (cand_y <= ly_q);
      default: in_region = 1'b0;
    endcase
`else
    in_region = 1'b1;
`endif
  end

  // Midpoint step taken after the eighth octant candidate
  coord_t oy_n, ox_n;
  crit_t  crit_n, diff;
  logic   arc_end;

  always_comb begin
    oy_n = oy_q + CoordOne;
    ox_n = ox_q;
    diff = '0;
    if (crit_q <= crit_t'(0)) begin
      crit_n = crit_q + crit_t'(oy_n) + crit_t'(oy_n) + CritOne;
    end else begin
      ox_n   = ox_q - CoordOne;
      diff   = crit_t'(oy_n) - crit_t'(ox_n);
      crit_n = crit_q + diff + diff + CritOne;
    end
    arc_end = (oy_n > ox_n);
  end

  always_comb begin
    state_d   = state_q;
    colour_d  = colour_q;
    cx_d      = cx_q;
    cy_d      = cy_q;
    diam_d    = diam_q;
    ay_d      = ay_q;
    bx_d      = bx_q;
    rx_d      = rx_q;
    ly_d      = ly_q;
    arc_d     = arc_q;
    oct_d     = oct_q;
    ox_d      = ox_q;
    oy_d      = oy_q;
    crit_d    = crit_q;
    vga_x_d   = vga_x_q;
    vga_y_d   = vga_y_q;
    vga_col_d = vga_col_q;
    plot_d    = 1'b0;
    done_d    = (state_q == StDone);
    unique case (state_q)
      StIdle: begin
        if (bus.start) begin
          state_d  = StSetup;
          colour_d = bus.colour;
          cx_d     = bus.centre_x;
          cy_d     = bus.centre_y;
          diam_d   = bus.diameter;
        end
      end
      StSetup: begin
        ay_d    = cy_s - h2;
        bx_d    = cx_s - half;
        rx_d    = cx_s + half;
        ly_d    = cy_s + h1;
        arc_d   = 2'd0;
        oct_d   = 3'd0;
        ox_d    = d_s;
        oy_d    = '0;
        crit_d  = CritOne - crit_t'(d_s);
        state_d = StArc;
      end
      StArc: begin
        vga_x_d   = cand_x[XW-1:0];
        vga_y_d   = cand_y[YW-1:0];
        vga_col_d = colour_q;
        plot_d    = on_screen && in_region;
        oct_d     = oct_q + 3'd1;
        if (oct_q == 3'd7) begin
          if (arc_end) begin
            // Re-arm the engine so the next arc starts without a gap cycle
            ox_d   = d_s;
            oy_d   = '0;
            crit_d = CritOne - crit_t'(d_s);
            if (arc_q == 2'd2) state_d = StDone;
            else               arc_d   = arc_q + 2'd1;
          end else begin
            ox_d   = ox_n;
            oy_d   = oy_n;
            crit_d = crit_n;
          end
        end
      end
      StDone: begin
        if (!bus.start) state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= StIdle;
      colour_q  <= '0;
      cx_q      <= '0;
      cy_q      <= '0;
      diam_q    <= '0;
      ay_q      <= '0;
      bx_q      <= '0;
      rx_q      <= '0;
      ly_q      <= '0;
      arc_q     <= '0;
      oct_q     <= '0;
      ox_q      <= '0;
      oy_q      <= '0;
      crit_q    <= '0;
      vga_x_q   <= '0;
      vga_y_q   <= '0;
      vga_col_q <= '0;
      plot_q    <= 1'b0;
      done_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      colour_q  <= colour_d;
      cx_q      <= cx_d;
      cy_q      <= cy_d;
      diam_q    <= diam_d;
      ay_q      <= ay_d;
      bx_q      <= bx_d;
      rx_q      <= rx_d;
      ly_q      <= ly_d;
      arc_q     <= arc_d;
      oct_q     <= oct_d;
      ox_q      <= ox_d;
      oy_q      <= oy_d;
      crit_q    <= crit_d;
      vga_x_q   <= vga_x_d;
      vga_y_q   <= vga_y_d;
      vga_col_q <= vga_col_d;
      plot_q    <= plot_d;
      done_q    <= done_d;
    end
  end

  assign bus.vga_x      = vga_x_q;
  assign bus.vga_y      = vga_y_q;
  assign bus.vga_colour = vga_col_q;
  assign bus.vga_plot   = plot_q;
  assign bus.done       = done_q;
endmodule

// File: tb/tb_reuleaux_arc.sv
// Self-checking bench for reuleaux_arc: table-driven and random draws compared against a
// candidate-list model, plus reset and handshake sequences.
module tb_reuleaux_arc;
  localparam int XW = 8;
  localparam int YW = 7;
  localparam int CW = 3;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  reuleaux_arc_if #(.XW(XW), .YW(YW), .CW(CW)) bus ();

  reuleaux_arc #(
    .XW(XW), .YW(YW), .CW(CW), .SCREEN_W(160), .SCREEN_H(120)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  typedef struct {
    int cx;
    int cy;
    int d;
    int col;
    int exp_n;  // hand-derived candidate total, 0 = take it from the model
  } vec_t;

  int checks = 0;
  int errors = 0;
  int ex_x[$];
  int ex_y[$];
  bit ex_p[$];
  int arc_len;
  int offscreen = 0;
  int bad_geo = 0;
  int bad_region = 0;
  int seen_b = 0;
  int seen_c = 0;
  int seen_wrap = 0;

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // Full candidate stream for one draw, straight from the arc/octant rules.
  function automatic void build_model(input int cx, input int cy, input int d);
    int vx[3];
    int vy[3];
    int ox, oy, crit, dx, dy, x, y, ly;
    bit keep;
    ex_x.delete();
    ex_y.delete();
    ex_p.delete();
    ly = cy + ((d * 37) >> 7);
    vx[0] = cx;            vy[0] = cy - ((d * 74) >> 7);
    vx[1] = cx - (d >> 1); vy[1] = ly;
    vx[2] = cx + (d >> 1); vy[2] = ly;
    for (int a = 0; a < 3; a++) begin
      ox = d; oy = 0; crit = 1 - d;
      do begin
        for (int o = 0; o < 8; o++) begin
          case (o)
            0: begin dx =  ox; dy =  oy; end
            1: begin dx =  oy; dy =  ox; end
            2: begin dx = -oy; dy =  ox; end
            3: begin dx = -ox; dy =  oy; end
            4: begin dx = -ox; dy = -oy; end
            5: begin dx = -oy; dy = -ox; end
            6: begin dx =  oy; dy = -ox; end
            default: begin dx = ox; dy = -oy; end
          endcase
          x = vx[a] + dx;
          y = vy[a] + dy;
`ifdef REULEAUX_CLIP_EN
          if (a == 0)      keep = (y >= ly);
          else if (a == 1) keep = (x >= cx) && (y <= ly);
          else             keep = (x <= cx) && (y <= ly);
`else
          keep = 1'b1;
`endif
          ex_x.push_back(x & ((1 << XW) - 1));
          ex_y.push_back(y & ((1 << YW) - 1));
          ex_p.push_back(keep && x >= 0 && x < 160 && y >= 0 && y < 120);
        end
        oy++;
        if (crit <= 0) crit += 2 * oy + 1;
        else begin
          ox--;
          crit += 2 * (oy - ox) + 1;
        end
      end while (oy <= ox);
    end
    arc_len = ex_x.size() / 3;
  endfunction

  task automatic run_draw(input vec_t v, input bit nominal);
    int n, mism, done_rel, stray, idx, a, px, py, cxa, cya, d2;
    build_model(v.cx, v.cy, v.d);
    n = ex_x.size();
    mism = 0;
    done_rel = 0;
    @(negedge clk);
    bus.centre_x = XW'(v.cx);
    bus.centre_y = YW'(v.cy);
    bus.diameter = XW'(v.d);
    bus.colour   = CW'(v.col);
    bus.start    = 1'b1;
    for (int rel = 1; rel <= n + 10; rel++) begin
      @(posedge clk);
      #1;
      if (rel == 1) begin
        // Inputs are latched; scramble them to prove it
        bus.centre_x = XW'($urandom);
        bus.centre_y = YW'($urandom);
        bus.diameter = XW'($urandom);
        bus.colour   = CW'($urandom);
      end
      idx = rel - 3;
      if (idx >= 0 && idx < n) begin
        if (bus.vga_plot !== ex_p[idx] || int'(bus.vga_x) != ex_x[idx] ||
            int'(bus.vga_y) != ex_y[idx] ||
            (ex_p[idx] && int'(bus.vga_colour) != v.col)) mism++;
      end else if (bus.vga_plot !== 1'b0) mism++;
      if (bus.vga_plot === 1'b1) begin
        px = int'(bus.vga_x);
        py = int'(bus.vga_y);
        if (px >= 160 || py >= 120) offscreen++;
        if (nominal && idx >= 0) begin
          a = idx / arc_len;
          cxa = (a == 0) ? 80 : (a == 1) ? 40 : 120;
          cya = (a == 0) ? 14 : 83;
          d2 = (px - cxa) * (px - cxa) + (py - cya) * (py - cya);
          if (d2 < 79 * 79 || d2 > 81 * 81) bad_geo++;
`ifdef REULEAUX_CLIP_EN
          if ((a == 0 && py < 83) || (a == 1 && (px < 80 || py > 83)) ||
              (a == 2 && (px > 80 || py > 83))) bad_region++;
`endif
          if (a == 0 && px == 40 && py == 83) seen_b++;
          if (a == 0 && px == 120 && py == 83) seen_c++;
          if (px == 80 && py == 35) seen_wrap++;
        end
      end
      if (bus.done === 1'b1) begin
        done_rel = rel;
        break;
      end
    end
    check("candidate_stream", mism, 0);
    check("done_latency", done_rel, ((v.exp_n > 0) ? v.exp_n : n) + 3);
    stray = 0;
    repeat (6) begin
      @(posedge clk);
      #1;
      if (bus.vga_plot !== 1'b0 || bus.done !== 1'b1) stray++;
    end
    check("hold_no_redraw", stray, 0);
    @(negedge clk);
    bus.start = 1'b0;
    @(posedge clk);
    #1;
    check("done_at_low_sample", int'(bus.done), 1);
    @(posedge clk);
    #1;
    check("done_fall", int'(bus.done), 0);
  endtask

  vec_t vecs[6];
  vec_t rv;
  int stray;

  initial begin
    vecs[0] = '{cx: 80,  cy: 60,  d: 80, col: 2, exp_n: 0};
    vecs[1] = '{cx: 10,  cy: 10,  d: 0,  col: 5, exp_n: 24};
    vecs[2] = '{cx: 5,   cy: 5,   d: 40, col: 7, exp_n: 0};
    vecs[3] = '{cx: 30,  cy: 20,  d: 1,  col: 1, exp_n: 48};
    vecs[4] = '{cx: 100, cy: 50,  d: 3,  col: 4, exp_n: 72};
    vecs[5] = '{cx: 150, cy: 110, d: 60, col: 6, exp_n: 0};

    rst = 1'b1;
    bus.start = 1'b0;
    bus.centre_x = '0;
    bus.centre_y = '0;
    bus.diameter = '0;
    bus.colour = '0;
    repeat (3) @(posedge clk);
    #1;
    check("reset_plot", int'(bus.vga_plot), 0);
    check("reset_x", int'(bus.vga_x), 0);
    check("reset_y", int'(bus.vga_y), 0);
    check("reset_colour", int'(bus.vga_colour), 0);
    check("reset_done", int'(bus.done), 0);
    @(negedge clk);
    rst = 1'b0;

    for (int i = 0; i < 6; i++) run_draw(vecs[i], i == 0);
    check("nominal_arc0_hits_B", int'(seen_b > 0), 1);
    check("nominal_arc0_hits_C", int'(seen_c > 0), 1);
    check("nominal_no_wrapped_80_163", seen_wrap, 0);
    check("nominal_radius", bad_geo, 0);
`ifdef REULEAUX_CLIP_EN
    check("nominal_region", bad_region, 0);
`endif

    for (int i = 0; i < 6; i++) begin
      rv.cx = int'($urandom_range(0, 255));
      rv.cy = int'($urandom_range(0, 127));
      rv.d = int'($urandom_range(0, 120));
      rv.col = int'($urandom_range(0, 7));
      rv.exp_n = 0;
      run_draw(rv, 1'b0);
    end
    check("never_plot_offscreen", offscreen, 0);

    // Reset part-way through arc 1
    build_model(80, 60, 80);
    @(negedge clk);
    bus.centre_x = 8'd80;
    bus.centre_y = 7'd60;
    bus.diameter = 8'd80;
    bus.colour = 3'b010;
    bus.start = 1'b1;
    repeat (2 + arc_len + 20) @(posedge clk);
    @(negedge clk);
    rst = 1'b1;
    bus.start = 1'b0;
    #1;
    check("midreset_plot", int'(bus.vga_plot), 0);
    check("midreset_x", int'(bus.vga_x), 0);
    check("midreset_y", int'(bus.vga_y), 0);
    check("midreset_colour", int'(bus.vga_colour), 0);
    check("midreset_done", int'(bus.done), 0);
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    stray = 0;
    repeat (40) begin
      @(posedge clk);
      #1;
      if (bus.vga_plot !== 1'b0 || bus.done !== 1'b0) stray++;
    end
    check("no_plot_after_reset", stray, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached, required finish");
    $fatal(1);
  end
endmodule
